// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU datapath constants and width defaults
package cpu_defs;

   // Architectural register numbers with fixed meaning
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Datapath widths shared by the destination mux and the register file
   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

endpackage

// File: rtl/regfile_wdemux_if.sv
// rtl/regfile_wdemux_if.sv - register file write/read port bundle
interface regfile_wdemux_if
   import cpu_defs::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
);

   logic              we;
   logic [AW-1:0]     wa;
   logic [DW-1:0]     wd;
   logic [AW-1:0]     ra1;
   logic [AW-1:0]     ra2;
   logic [DW-1:0]     rd1;
   logic [DW-1:0]     rd2;
   logic [2**AW-1:0]  wsel;

   // Datapath side: drives write-back and read addresses
   modport master (
      output we, wa, wd, ra1, ra2,
      input  rd1, rd2, wsel
   );

   // Register file side
   modport slave (
      input  we, wa, wd, ra1, ra2,
      output rd1, rd2, wsel
   );

endinterface

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - enable-gated binary to one-hot decoder
module dec_onehot #(
   parameter int AW = 5
) (
   input  logic              en,
   input  logic [AW-1:0]     addr,
   output logic [2**AW-1:0]  onehot
);

   // Enable is tested before the address so an unknown address cannot leak through when idle
   always_comb begin
      onehot = '0;
      if (en) begin
         for (int i = 0; i < 2**AW; i++) begin
            onehot[i] = (addr == AW'(i));
         end
      end
   end

endmodule

// File: rtl/regfile_wdemux.sv
// rtl/regfile_wdemux.sv - 2**AW x DW register file with one-hot write demux
module regfile_wdemux
   import cpu_defs::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter bit BYPASS = 1'b0
) (
   input  logic             clk,
   input  logic             clrn,
   regfile_wdemux_if.slave  bus
);

   localparam int NR = 2**AW;

   logic [NR-1:0] dec_raw;
   logic [NR-1:0] dec;
   logic [NR-1:0] wsel_q;
   logic [DW-1:0] regs [NR];

   dec_onehot #(.AW(AW)) u_dec (
      .en     (bus.we),
      .addr   (bus.wa),
      .onehot (dec_raw)
   );

   // Register 0 is never a write target, so its decode line is masked off
   assign dec = dec_raw & {{(NR-1){1'b1}}, 1'b0};

   // Steer write-back into the single decoded register; record the decode for trace
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < NR; i++) begin
            regs[i] <= '0;
         end
         wsel_q <= '0;
      end else begin
         for (int i = 1; i < NR; i++) begin
            if (dec[i]) begin
               regs[i] <= bus.wd;
            end
         end
         wsel_q <= dec;
      end
   end

   assign bus.wsel = wsel_q;

   // Address 0 reads as zero; optional write-through forwards wd on an address match
   assign bus.rd1 = (bus.ra1 == AW'(REG_ZERO))                ? '0     :
                    (BYPASS && bus.we && (bus.wa == bus.ra1)) ? bus.wd :
                                                                regs[bus.ra1];

   assign bus.rd2 = (bus.ra2 == AW'(REG_ZERO))                ? '0     :
                    (BYPASS && bus.we && (bus.wa == bus.ra2)) ? bus.wd :
                                                                regs[bus.ra2];

endmodule

// File: doc/regfile_wdemux.md
Name: regfile_wdemux

Overview:
- 32 x 32-bit MIPS general-purpose register file for the single-cycle CPU.
- Write-back side: a 5-to-32 one-hot write decoder (demultiplexer) steers the write-back value into exactly one register. This is the counterpart of the datapath's read-side selectors.
- Two combinational read ports feed the ALU operand muxes.
- Register $0 is hardwired to zero.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; register count is 2**AW.
- BYPASS, 0, if 1, a read of the address being written in the same cycle returns the write data (write-through).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clrn  input  1  asynchronous active-low reset.
- we  input  1  write enable from control unit.
- wa  input  AW  write address (selected rd/rt/31 from the destination mux).
- wd  input  DW  write-back data.
- ra1  input  AW  read address port 1 (rs).
- ra2  input  AW  read address port 2 (rt).
- rd1  output  DW  read data port 1.
- rd2  output  DW  read data port 2.
- wsel  output  2**AW  registered one-hot copy of the last accepted write decode, for debug/trace; 0 when no write occurred.

Behaviour:
- Reset: clrn low asynchronously clears all registers to 0 and wsel to 0. Reset is held regardless of clk. Release takes effect at the next rising edge.
- Decoder: dec[i] = we & (wa == i) for i = 1..2**AW-1. dec[0] is forced to 0. At most one bit of dec is set.
- Write: on a rising clk with clrn high, every register i with dec[i] = 1 loads wd. All other registers hold.
- Write latency is one cycle: the value is visible on rd1/rd2 from the cycle after the edge.
- wsel loads dec on every rising edge, so wsel is all-zero after a cycle with we = 0 or wa = 0.
- Reads: rd1/rd2 are purely combinational from ra1/ra2 and register contents.
  - ra = 0 always returns 0, even after an attempted write to $0.
- Same-cycle read/write of one address:
  - BYPASS = 0: the read returns the old value until the edge.
  - BYPASS = 1: the read returns wd when we = 1, wa == ra and wa != 0.
- Both read ports may address the same register simultaneously; both return the identical value.
- we = 1 with wa = 0: no state change; wsel becomes 0.
- X on wa while we = 0 must not corrupt any register. The decoder gates on we first.
- Reset asserted in the same cycle as a write: reset wins and the register reads 0.

Decomposition:
- Shared package cpu_defs holds:
  - constants REG_ZERO = 5'd0 and REG_RA = 5'd31.
  - DW/AW defaults, so the destination mux and the register file agree on widths.
- One natural sub-module: dec_onehot (parameter AW, inputs en and addr, output 2**AW one-hot). It is reusable for any future memory-mapped write steering.
- The register array and read muxing stay in regfile_wdemux.

Test Plan:
- Reset: write 32'hDEADBEEF to r5, pulse clrn low mid-cycle (not at an edge) -> rd1 for ra1 = 5 reads 0 immediately; wsel = 0.
- Basic write/read: we = 1, wa = 7, wd = 32'h12345678 at edge N -> from cycle N+1, ra1 = 7 reads 32'h12345678 and wsel = 32'h00000080. Next cycle with we = 0 -> wsel = 0 and r7 holds.
- $0 protection: we = 1, wa = 0, wd = 32'hFFFFFFFF -> rd1 for ra1 = 0 stays 0; wsel = 0.
- Same-cycle hazard: r9 = 32'h1, then we = 1, wa = 9, wd = 32'h2, ra2 = 9 before the edge -> rd2 = 32'h1 for BYPASS = 0, 32'h2 for BYPASS = 1. After the edge it is 32'h2 in both builds.
- Dual-port/exhaustive: write r[i] = i*32'h01010101 for i = 1..31, then sweep ra1 = i, ra2 = 31-i -> each port returns its expected value. Index 0 returns 0. No other register is disturbed by any write, checked against a scoreboard model.
- Reset vs write collision: clrn low during the edge with we = 1, wa = 3, wd = 32'hA5A5A5A5 -> after release, r3 reads 0.
